// File: rtl/ktc32_pkg.sv
// Shared types for the ktc32 boot loader: loader FSM states and frame field widths.
package ktc32_pkg;

   localparam int LEN_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      WRITE,
      CSUM,
      DONE,
      ERR
   } ld_state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted stream bytes LSB-first into a 32-bit word and flags the 4th byte.
module byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  in_data,
   output logic [31:0] word_next,
   output logic        word_ready
);

   logic [1:0]  cnt;
   logic [31:0] shreg;

   // word_next is the register value after this byte shifts in, so on the 4th
   // byte it is already the complete {b3,b2,b1,b0} word.
   assign word_next  = {in_data, shreg[31:8]};
   assign word_ready = accept && (cnt == 2'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= 2'd0;
      else if (clear)
         cnt <= 2'd0;
      else if (accept)
         cnt <= cnt + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (accept)
         shreg <= word_next;
   end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream, writes 32-bit words
// from address 0, verifies the XOR checksum and then releases the core.
module prog_loader
   import ktc32_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int MAX_N = 1 << ADDR_WIDTH;

   ld_state_t        state, state_nx;
   logic [LEN_W:0]   word_idx;
   logic [LEN_W:0]   idx_inc;
   logic [LEN_W:0]   hdr_n;
   logic [LEN_W-1:0] n_words;
   logic [7:0]       n_lo;
   logic [7:0]       csum;
   logic             accept;
   logic             start_ok;
   logic             pk_accept;
   logic             bad_len;
   logic             word_ready;
   logic [31:0]      word_next;

   assign accept    = in_valid && in_ready;
   assign pk_accept = accept && (state == DATA);
   assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
   assign hdr_n     = {1'b0, in_data, n_lo};
   assign idx_inc   = word_idx + 1'b1;
   assign bad_len   = (hdr_n == '0) || (int'(hdr_n) > MAX_N);

   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_ok),
      .accept     (pk_accept),
      .in_data    (in_data),
      .word_next  (word_next),
      .word_ready (word_ready)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      mem_we    = 1'b0;
      cpu_reset = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = HDR0;
         end
         HDR0: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_nx = HDR1;
         end
         HDR1: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_nx = bad_len ? ERR : DATA;
         end
         DATA: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (word_ready) state_nx = WRITE;
         end
         WRITE: begin
            busy     = 1'b1;
            mem_we   = 1'b1;
            state_nx = (idx_inc < {1'b0, n_words}) ? DATA : CSUM;
         end
         CSUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) state_nx = (in_data == csum) ? DONE : ERR;
         end
         DONE: begin
            cpu_reset = 1'b0;
            done      = 1'b1;
            if (start) state_nx = HDR0;
         end
         ERR: begin
            err = 1'b1;
            if (start) state_nx = HDR0;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Address/data are captured on the 4th-byte edge so they are valid throughout
   // WRITE and then hold until the next word completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_idx  <= '0;
         n_lo      <= '0;
         n_words   <= '0;
         csum      <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (start_ok) begin
            word_idx <= '0;
            csum     <= '0;
         end
         if (accept && (state == HDR0))
            n_lo <= in_data;
         if (accept && (state == HDR1))
            n_words <= {in_data, n_lo};
         if (pk_accept)
            csum <= csum ^ in_data;
         if (word_ready) begin
            mem_addr  <= word_idx[ADDR_WIDTH-1:0];
            mem_wdata <= word_next;
         end
         if (state == WRITE)
            word_idx <= idx_inc;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, length limits, stalls and reset abort.
module tb_prog_loader;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_reset;
   logic          busy;
   logic          done;
   logic          err;

   int            compared   = 0;
   int            mismatched = 0;
   int            wcount     = 0;
   int            wbase;
   logic [AW-1:0] last_addr;
   logic [31:0]   mem [256];
   logic [7:0]    cs;
   logic [7:0]    pay [8];

   prog_loader #(.ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Memory model: records every write strobe seen mid-cycle.
   always @(negedge clk) begin
      if (mem_we) begin
         wcount    = wcount + 1;
         last_addr = mem_addr;
         mem[mem_addr] = mem_wdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      t = 0;
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         compared++;
         mismatched++;
         $error("FAIL send_timeout: in_ready observed 0 expected 1");
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 7 + 3) & 255);
   endfunction

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready), 0);
      chk("rst_mem_we",    32'(mem_we), 0);
      chk("rst_mem_addr",  32'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_reset", 32'(cpu_reset), 1);
      chk("rst_busy",      32'(busy), 0);
      chk("rst_done",      32'(done), 0);
      chk("rst_err",       32'(err), 0);
      @(negedge clk);
      reset = 1'b0;

      // Good 1-word frame
      wbase = wcount;
      pulse_start();
      chk("g_busy_hdr0",  32'(busy), 1);
      chk("g_ready_hdr0", 32'(in_ready), 1);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h78, 0);
      send_byte(8'h56, 0);
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      chk("g_we",    32'(mem_we), 1);
      chk("g_addr",  32'(mem_addr), 0);
      chk("g_wdata", mem_wdata, 32'h12345678);
      chk("g_ready_write", 32'(in_ready), 0);
      send_byte(8'h08, 0);
      chk("g_done",   32'(done), 1);
      chk("g_cpurst", 32'(cpu_reset), 0);
      chk("g_busy",   32'(busy), 0);
      chk("g_err",    32'(err), 0);
      #10;
      chk("g_writes", 32'(wcount - wbase), 1);
      chk("g_mem0",   mem[0], 32'h12345678);

      // Bad checksum, started from DONE
      wbase = wcount;
      pulse_start();
      chk("b_cpurst_restart", 32'(cpu_reset), 1);
      chk("b_done_cleared",   32'(done), 0);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h78, 0);
      send_byte(8'h56, 0);
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      send_byte(8'h09, 0);
      chk("b_err",    32'(err), 1);
      chk("b_cpurst", 32'(cpu_reset), 1);
      chk("b_done",   32'(done), 0);
      #10;
      chk("b_writes", 32'(wcount - wbase), 1);

      // Zero length, started from ERR
      wbase = wcount;
      pulse_start();
      chk("z_err_cleared", 32'(err), 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("z_err",      32'(err), 1);
      chk("z_in_ready", 32'(in_ready), 0);
      chk("z_busy",     32'(busy), 0);
      #20;
      chk("z_writes",   32'(wcount - wbase), 0);

      // Oversize N = 257
      wbase = wcount;
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      chk("o_err", 32'(err), 1);
      #20;
      chk("o_writes", 32'(wcount - wbase), 0);

      // Maximum N = 256 fills the whole memory
      wbase = wcount;
      cs = 8'h00;
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      for (int i = 0; i < 1024; i++) begin
         send_byte(pat(i), 0);
         cs ^= pat(i);
      end
      send_byte(cs, 0);
      chk("m_done", 32'(done), 1);
      #10;
      chk("m_writes",    32'(wcount - wbase), 256);
      chk("m_last_addr", 32'(last_addr), 32'hFF);
      chk("m_mem0",   mem[0],   {pat(3), pat(2), pat(1), pat(0)});
      chk("m_memFF",  mem[255], {pat(1023), pat(1022), pat(1021), pat(1020)});

      // 2-word frame with random gaps and an ignored mid-frame start
      pay = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
      wbase = wcount;
      cs = 8'h00;
      pulse_start();
      send_byte(8'h02, $urandom_range(0, 2));
      send_byte(8'h00, $urandom_range(0, 2));
      pulse_start();
      chk("s_ignored_busy", 32'(busy), 1);
      for (int i = 0; i < 8; i++) begin
         send_byte(pay[i], $urandom_range(0, 3));
         cs ^= pay[i];
      end
      send_byte(cs, $urandom_range(0, 2));
      chk("s_done", 32'(done), 1);
      #10;
      chk("s_writes", 32'(wcount - wbase), 2);
      chk("s_mem0", mem[0], 32'hDEADBEEF);
      chk("s_mem1", mem[1], 32'h0BADF00D);
      chk("s_last_addr", 32'(last_addr), 1);

      // Reset in the middle of a 2-word frame
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      chk("r_we_before", 32'(mem_we), 1);
      reset = 1'b1;
      #1;
      chk("r_mem_we",    32'(mem_we), 0);
      chk("r_mem_addr",  32'(mem_addr), 0);
      chk("r_mem_wdata", mem_wdata, 0);
      chk("r_cpu_reset", 32'(cpu_reset), 1);
      chk("r_busy",      32'(busy), 0);
      chk("r_in_ready",  32'(in_ready), 0);
      chk("r_done",      32'(done), 0);
      chk("r_err",       32'(err), 0);
      @(negedge clk);
      reset = 1'b0;
      wbase = wcount;
      pulse_start();
      chk("r2_busy", 32'(busy), 1);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h0D, 0);
      send_byte(8'hF0, 0);
      send_byte(8'hFE, 0);
      send_byte(8'hCA, 0);
      send_byte(8'hC9, 0);
      chk("r2_done", 32'(done), 1);
      #10;
      chk("r2_writes", 32'(wcount - wbase), 1);
      chk("r2_mem0", mem[0], 32'hCAFEF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
